median_image_ctrl: RTL and testbench

Frame sequencer for the MEDIAN 3x3 filter core. On START it walks a 2^W_LOG2 x 2^H_LOG2 8-bit image held in a synchronous-read source RAM in raster order. For each pixel it fetches the 9 neighbours with edge clamping and streams them into MEDIAN under DSI. It waits for DSO and writes the median to a destination RAM at the same address. It replaces the behavioural pixel feeder so the filter runs stand-alone on a frame buffer.

---
 rtl/median_image_ctrl.sv | 178 +++++++++++++++++
 tb/tb_median_image_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/median_image_ctrl.sv
// Frame sequencer for the MEDIAN 3x3 core: streams clamped 3x3 windows from a
// source RAM into MEDIAN and writes each median back at the centre pixel address.
module median_image_ctrl #(
    parameter int W_LOG2 = 8,
    parameter int H_LOG2 = 8
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     START,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [W_LOG2+H_LOG2-1:0] RADDR,
    input  logic [7:0]               RDATA,
    output logic [7:0]               MDI,
    output logic                     MDSI,
    input  logic [7:0]               MDO,
    input  logic                     MDSO,
    output logic [W_LOG2+H_LOG2-1:0] WADDR,
    output logic [7:0]               WDATA,
    output logic                     WE
);

    localparam logic [W_LOG2-1:0] XMAX = '1;
    localparam logic [H_LOG2-1:0] YMAX = '1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_WRITE, S_DONE} state_t;

    state_t                     state_q, state_d;
    logic [W_LOG2-1:0]          x_q, x_d;
    logic [H_LOG2-1:0]          y_q, y_d;
    logic [3:0]                 k_q, k_d;
    logic [W_LOG2+H_LOG2-1:0]   raddr_q, raddr_d;
    logic [W_LOG2+H_LOG2-1:0]   waddr_q, waddr_d;
    logic [7:0]                 wdata_q, wdata_d;
    logic                       issue_q, issue_d;
    logic                       mdsi_q, mdsi_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       we_q, we_d;

    logic [1:0]                 row, col;
    logic [W_LOG2-1:0]          rx;
    logic [H_LOG2-1:0]          ry;

    assign MDI   = RDATA;
    assign RADDR = raddr_q;
    assign MDSI  = mdsi_q;
    assign WADDR = waddr_q;
    assign WDATA = wdata_q;
    assign WE    = we_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;

    // Neighbour offset codes: 0 -> -1, 1 -> 0, 2 -> +1 (row-major, top-left first)
    always_comb begin
        row = 2'd0;
        col = 2'd0;
        case (k_q)
            4'd0: begin row = 2'd0; col = 2'd0; end
            4'd1: begin row = 2'd0; col = 2'd1; end
            4'd2: begin row = 2'd0; col = 2'd2; end
            4'd3: begin row = 2'd1; col = 2'd0; end
            4'd4: begin row = 2'd1; col = 2'd1; end
            4'd5: begin row = 2'd1; col = 2'd2; end
            4'd6: begin row = 2'd2; col = 2'd0; end
            4'd7: begin row = 2'd2; col = 2'd1; end
            default: begin row = 2'd2; col = 2'd2; end
        endcase
    end

    // Clamp at the frame border: an offset that would leave the image stays on the edge
    always_comb begin
        rx = x_q;
        ry = y_q;
        case (col)
            2'd0:    rx = (x_q == '0)   ? x_q : x_q - W_LOG2'(1);
            2'd2:    rx = (x_q == XMAX) ? x_q : x_q + W_LOG2'(1);
            default: rx = x_q;
        endcase
        case (row)
            2'd0:    ry = (y_q == '0)   ? y_q : y_q - H_LOG2'(1);
            2'd2:    ry = (y_q == YMAX) ? y_q : y_q + H_LOG2'(1);
            default: ry = y_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        k_d     = k_q;
        raddr_d = raddr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        issue_d = 1'b0;
        mdsi_d  = issue_q;
        done_d  = 1'b0;
        we_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    state_d = S_FETCH;
                    x_d     = '0;
                    y_d     = '0;
                    k_d     = '0;
                    busy_d  = 1'b1;
                end
            end
            S_FETCH: begin
                raddr_d = {ry, rx};
                issue_d = 1'b1;
                if (k_q == 4'd8) state_d = S_WAIT;
                else             k_d = k_q + 4'd1;
            end
            S_WAIT: begin
                // Only trust MDSO once the whole window has been pushed into MEDIAN
                if (MDSO && !mdsi_q && !issue_q) begin
                    wdata_d = MDO;
                    waddr_d = {y_q, x_q};
                    we_d    = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                k_d = '0;
                if (x_q == XMAX) begin
                    x_d = '0;
                    if (y_q == YMAX) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        y_d     = y_q + H_LOG2'(1);
                        state_d = S_FETCH;
                    end
                end else begin
                    x_d     = x_q + W_LOG2'(1);
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            issue_q <= 1'b0;
            mdsi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            k_q     <= k_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            issue_q <= issue_d;
            mdsi_q  <= mdsi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
        end
    end

endmodule

// File: tb/tb_median_image_ctrl.sv
// Directed bench for median_image_ctrl on a 4x4 frame with a behavioural MEDIAN stub.
module tb_median_image_ctrl;

    localparam int WL = 2;
    localparam int HL = 2;
    localparam int N  = 16;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        START;
    logic        BUSY, DONE, MDSI, WE, MDSO;
    logic [3:0]  RADDR, WADDR;
    logic [7:0]  RDATA, MDI, MDO, WDATA;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    median_image_ctrl #(.W_LOG2(WL), .H_LOG2(HL)) dut (
        .CLK(CLK), .nRST(nRST), .START(START), .BUSY(BUSY), .DONE(DONE),
        .RADDR(RADDR), .RDATA(RDATA), .MDI(MDI), .MDSI(MDSI), .MDO(MDO),
        .MDSO(MDSO), .WADDR(WADDR), .WDATA(WDATA), .WE(WE)
    );

    logic [7:0] src [N];

    always @(posedge CLK) RDATA <= src[RADDR];

    function automatic logic [7:0] med9(input logic [7:0] v [9]);
        logic [7:0] a [9];
        logic [7:0] t;
        a = v;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        return a[4];
    endfunction

    function automatic logic [7:0] exp_pix(input int x, input int y);
        logic [7:0] v [9];
        int cx, cy, n;
        n = 0;
        for (int i = -1; i <= 1; i++)
            for (int j = -1; j <= 1; j++) begin
                cx = x + j; cy = y + i;
                if (cx < 0) cx = 0; if (cx > 3) cx = 3;
                if (cy < 0) cy = 0; if (cy > 3) cy = 3;
                v[n] = src[cy*4 + cx];
                n++;
            end
        return med9(v);
    endfunction

    // MEDIAN stub: collects 9 DSI samples, answers lat cycles after the last one
    int         lat;
    logic [7:0] sw [9];
    int         sn, scnt;
    logic [7:0] smed;
    always @(posedge CLK or negedge nRST) begin : stub
        logic [7:0] tmp [9];
        if (!nRST) begin
            sn <= 0; scnt <= 0; MDSO <= 1'b0; MDO <= 8'h00;
        end else begin
            MDSO <= 1'b0;
            if (MDSI) begin
                sw[sn] <= MDI;
                if (sn == 8) begin
                    tmp = sw; tmp[8] = MDI;
                    smed <= med9(tmp);
                    scnt <= lat;
                    sn   <= 0;
                end else sn <= sn + 1;
            end else if (scnt > 0) begin
                scnt <= scnt - 1;
                if (scnt == 1) begin MDSO <= 1'b1; MDO <= smed; end
            end
        end
    end

    // Monitor: read addresses per window, MDSI run/gap shape, writes, DONE pulses
    logic       log_clr;
    logic [3:0] prev_raddr;
    logic [3:0] alog [144];
    logic [3:0] wlog_a [N];
    logic [7:0] wlog_d [N];
    int mlog_n, wr_cnt, done_cnt, run, gap, min_gap, bad_run;
    logic mprev, seen;
    always @(posedge CLK) begin
        prev_raddr <= RADDR;
        if (log_clr) begin
            mlog_n <= 0; wr_cnt <= 0; done_cnt <= 0; run <= 0; gap <= 0;
            min_gap <= 1000; bad_run <= 0; mprev <= 1'b0; seen <= 1'b0;
        end else begin
            if (MDSI) begin
                if (mlog_n < 144) alog[mlog_n] <= prev_raddr;
                mlog_n <= mlog_n + 1;
                run    <= mprev ? run + 1 : 1;
                if (!mprev && seen && gap < min_gap) min_gap <= gap;
            end else begin
                gap <= mprev ? 1 : gap + 1;
                if (mprev) begin
                    seen <= 1'b1;
                    if (run != 9) bad_run <= bad_run + 1;
                end
            end
            mprev <= MDSI;
            if (WE) begin
                if (wr_cnt < N) begin wlog_a[wr_cnt] <= WADDR; wlog_d[wr_cnt] <= WDATA; end
                wr_cnt <= wr_cnt + 1;
            end
            if (DONE) done_cnt <= done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        @(negedge CLK) log_clr = 1'b1;
        @(negedge CLK) log_clr = 1'b0;
    endtask

    task automatic start_frame();
        @(negedge CLK) START = 1'b1;
        @(negedge CLK) START = 1'b0;
        chk("busy_after_start", BUSY, 1);
    endtask

    task automatic wait_done(input int budget, input bit poke);
        bit got = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge CLK);
            if (poke) START = (c % 7 == 3);
            if (DONE) begin got = 1'b1; break; end
        end
        START = 1'b0;
        chk("done_seen", got, 1);
        if (got) begin
            @(negedge CLK);
            chk("busy_low_after_done", BUSY, 0);
        end
        repeat (3) @(negedge CLK);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_writes"}, wr_cnt, N);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        for (int i = 0; i < N; i++) begin
            chk({tag, "_waddr"}, wlog_a[i], i);
            chk({tag, "_wdata"}, wlog_d[i], exp_pix(i % 4, i / 4));
        end
    endtask

    logic [7:0] first [N];
    logic [3:0] win0 [9];
    logic [3:0] win15 [9];

    initial begin
        bit hit;
        win0  = '{4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd1, 4'd4, 4'd4, 4'd5};
        win15 = '{4'd10, 4'd11, 4'd11, 4'd14, 4'd15, 4'd15, 4'd14, 4'd15, 4'd15};
        lat = 3;
        log_clr = 1'b1;
        for (int i = 0; i < N; i++) src[i] = 8'(i);

        // Reset with junk on START
        nRST = 1'b0;
        START = 1'b1;
        repeat (3) @(negedge CLK) START = 1'($urandom);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_we", WE, 0);
        chk("rst_mdsi", MDSI, 0);
        chk("rst_raddr", RADDR, 0);
        chk("rst_waddr", WADDR, 0);
        chk("rst_wdata", WDATA, 0);
        START = 1'b0;
        @(negedge CLK) nRST = 1'b1;
        log_clr = 1'b0;
        repeat (6) @(negedge CLK);
        chk("idle_busy", BUSY, 0);
        chk("idle_mdsi", MDSI, 0);
        chk("idle_writes", wr_cnt, 0);

        // Address order and window shape, src = address
        clear_logs();
        start_frame();
        wait_done(2000, 1'b0);
        chk("windows_mdsi_cycles", mlog_n, 144);
        chk("mdsi_runs_of_9", bad_run, 0);
        for (int n = 0; n < 9; n++) begin
            chk("raddr_pix00", alog[n], win0[n]);
            chk("raddr_pix33", alog[135 + n], win15[n]);
        end
        check_frame("ramp_addr");

        // Uniform 0x80
        for (int i = 0; i < N; i++) src[i] = 8'h80;
        clear_logs();
        start_frame();
        wait_done(2000, 1'b0);
        chk("uni_writes", wr_cnt, N);
        chk("uni_done_pulses", done_cnt, 1);
        for (int i = 0; i < N; i++) begin
            chk("uni_waddr", wlog_a[i], i);
            chk("uni_wdata", wlog_d[i], 8'h80);
        end

        // Latency independence on an 8-level ramp
        for (int i = 0; i < N; i++) src[i] = 8'(((i * 5) % 8) * 32);
        lat = 1;
        clear_logs();
        start_frame();
        wait_done(2000, 1'b0);
        check_frame("lat1");
        chk("lat1_min_gap_ok", min_gap >= 2, 1);
        for (int i = 0; i < N; i++) first[i] = wlog_d[i];
        lat = 20;
        clear_logs();
        start_frame();
        wait_done(4000, 1'b0);
        chk("lat20_writes", wr_cnt, N);
        chk("lat20_windows", mlog_n, 144);
        chk("lat20_min_gap_ok", min_gap >= 2, 1);
        for (int i = 0; i < N; i++) chk("lat20_vs_lat1", wlog_d[i], first[i]);

        // START hammered while busy
        lat = 2;
        for (int i = 0; i < N; i++) src[i] = 8'($urandom);
        clear_logs();
        start_frame();
        wait_done(2000, 1'b1);
        check_frame("start_abuse");

        // Reset during the 5th write, then a clean restart
        clear_logs();
        start_frame();
        hit = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge CLK);
            if (WE && wr_cnt == 4) begin hit = 1'b1; break; end
        end
        chk("fifth_write_seen", hit, 1);
        nRST = 1'b0;
        #1;
        chk("midrst_we", WE, 0);
        chk("midrst_mdsi", MDSI, 0);
        chk("midrst_busy", BUSY, 0);
        chk("midrst_raddr", RADDR, 0);
        @(negedge CLK) nRST = 1'b1;
        clear_logs();
        start_frame();
        wait_done(2000, 1'b0);
        check_frame("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
